// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and AHB-Lite constants for the DMA master
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_D = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_D = 3'd4,
        ST_DONE = 3'd5
    } dma_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

endpackage

// File: rtl/ahb_dma_master.sv
// rtl/ahb_dma_master.sv - AHB-Lite word copy engine (optional fill mode: DMA_FILL_EN)
module ahb_dma_master
    import dma_pkg::*;
#(
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
`ifdef DMA_FILL_EN
    input  logic              fill,
    input  logic [31:0]       fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [3:0]        HPROT,
    output logic              HMASTLOCK,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [31:0]       data_reg_q, data_reg_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic [ADDR_W-1:0] haddr_q;
    logic              err_q, err_d;
    logic              fill_q, fill_d;

    // Fill requests only exist when the feature is built in; otherwise every start is a copy.
    logic              start_fill;
    logic [31:0]       start_fill_value;
`ifdef DMA_FILL_EN
    assign start_fill       = fill;
    assign start_fill_value = fill_value;
`else
    assign start_fill       = 1'b0;
    assign start_fill_value = 32'h0;
`endif

    // Address-phase outputs decode from state; HADDR keeps its last driven value elsewhere.
    always_comb begin
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
        HADDR  = haddr_q;
        if (state_q == ST_RD_A) begin
            HTRANS = HTRANS_NONSEQ;
            HADDR  = src_ptr_q;
        end else if (state_q == ST_WR_A) begin
            HTRANS = HTRANS_NONSEQ;
            HWRITE = 1'b1;
            HADDR  = dst_ptr_q;
        end
    end

    assign busy      = (state_q == ST_RD_A) || (state_q == ST_RD_D) ||
                       (state_q == ST_WR_A) || (state_q == ST_WR_D);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign HWDATA    = hwdata_q;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA;
    assign HMASTLOCK = 1'b0;

    // Next-state logic: one word is read, then written; an error response in either data phase ends the job.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        data_reg_d  = data_reg_q;
        hwdata_d    = hwdata_q;
        err_d       = err_q;
        fill_d      = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        src_ptr_d   = {src_addr[ADDR_W-1:2], 2'b00};
                        dst_ptr_d   = {dst_addr[ADDR_W-1:2], 2'b00};
                        remaining_d = len;
                        fill_d      = start_fill;
                        if (start_fill) begin
                            data_reg_d = start_fill_value;
                            state_d    = ST_WR_A;
                        end else begin
                            state_d    = ST_RD_A;
                        end
                    end
                end
            end
            ST_RD_A: begin
                if (HREADY) state_d = ST_RD_D;
            end
            ST_RD_D: begin
                if (HRESP) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (HREADY) begin
                    data_reg_d = HRDATA;
                    src_ptr_d  = src_ptr_q + WORD_STEP;
                    state_d    = ST_WR_A;
                end
            end
            ST_WR_A: begin
                if (HREADY) begin
                    hwdata_d = data_reg_q;
                    state_d  = ST_WR_D;
                end
            end
            ST_WR_D: begin
                if (HRESP) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (HREADY) begin
                    dst_ptr_d   = dst_ptr_q + WORD_STEP;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) state_d = ST_DONE;
                    else if (fill_q)              state_d = ST_WR_A;
                    else                          state_d = ST_RD_A;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any in-flight bus transfer immediately.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            data_reg_q  <= '0;
            hwdata_q    <= '0;
            haddr_q     <= '0;
            err_q       <= 1'b0;
            fill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            data_reg_q  <= data_reg_d;
            hwdata_q    <= hwdata_d;
            haddr_q     <= HADDR;
            err_q       <= err_d;
            fill_q      <= fill_d;
        end
    end

endmodule
